// File: rtl/dma_regs_pkg.sv
// dma_regs_pkg: AXI DMA register map, control/status constants, error codes and launcher FSM states
package dma_regs_pkg;
   localparam logic [9:0] MM2S_DMACR        = 10'h00;
   localparam logic [9:0] MM2S_DMASR        = 10'h04;
   localparam logic [9:0] MM2S_CURDESC_LSB  = 10'h08;
   localparam logic [9:0] MM2S_CURDESC_MSB  = 10'h0C;
   localparam logic [9:0] MM2S_TAILDESC_LSB = 10'h10;
   localparam logic [9:0] MM2S_TAILDESC_MSB = 10'h14;
   localparam logic [9:0] S2MM_DMACR        = 10'h30;
   localparam logic [9:0] S2MM_DMASR        = 10'h34;
   localparam logic [9:0] S2MM_CURDESC_LSB  = 10'h38;
   localparam logic [9:0] S2MM_CURDESC_MSB  = 10'h3C;
   localparam logic [9:0] S2MM_TAILDESC_LSB = 10'h40;
   localparam logic [9:0] S2MM_TAILDESC_MSB = 10'h44;
   localparam logic [31:0] DMACR_RS_IOCEN = 32'h0000_1001;
   localparam int          DMASR_IOC      = 12;
   localparam logic [31:0] DMASR_IOC_W1C  = 32'h0000_1000;
   localparam logic [31:0] DMASR_ERR      = 32'h0000_0070;
   localparam logic [3:0]  LAST_STEP      = 4'd9;
   localparam logic [2:0] ERR_NONE    = 3'd0;
   localparam logic [2:0] ERR_BRESP   = 3'd1;
   localparam logic [2:0] ERR_RRESP   = 3'd2;
   localparam logic [2:0] ERR_MM2S    = 3'd3;
   localparam logic [2:0] ERR_S2MM    = 3'd4;
   localparam logic [2:0] ERR_TIMEOUT = 3'd5;
   typedef logic [3:0] state_t;
   localparam state_t S_IDLE     = 4'd0;
   localparam state_t S_WR_REQ   = 4'd1;
   localparam state_t S_WR_RESP  = 4'd2;
   localparam state_t S_RD_REQ   = 4'd3;
   localparam state_t S_RD_RESP  = 4'd4;
   localparam state_t S_EVAL     = 4'd5;
   localparam state_t S_CLR_REQ  = 4'd6;
   localparam state_t S_CLR_RESP = 4'd7;
   localparam state_t S_DONE     = 4'd8;
   localparam state_t S_ERR      = 4'd9;
endpackage

// File: rtl/dma_sg_launcher_if.sv
// dma_sg_launcher_if: AXI4-Lite bus bundle with master/slave views
interface dma_sg_launcher_if #(parameter int ADDR_W = 10);
   logic [ADDR_W-1:0] awaddr;
   logic              awvalid, awready;
   logic [31:0]       wdata;
   logic [3:0]        wstrb;
   logic              wvalid, wready;
   logic [1:0]        bresp;
   logic              bvalid, bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid, arready;
   logic [31:0]       rdata;
   logic [1:0]        rresp;
   logic              rvalid, rready;
   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_single_master.sv
// axil_single_master: one-shot AXI4-Lite write/read engine, one transaction at a time, ack on B/R beat
module axil_single_master #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ack,
   output logic [1:0]        resp,
   output logic [31:0]       rdata,
   dma_sg_launcher_if.master m_axil
);
   logic awv_q, awv_d, wv_q, wv_d, bready_q, bready_d;
   logic arv_q, arv_d, rready_q, rready_d, idle, start;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   always_comb begin
      idle     = ~(awv_q | wv_q | bready_q | arv_q | rready_q);
      start    = idle & (wr_req | rd_req);
      awv_d    = (wr_req & idle) | (awv_q & ~m_axil.awready);
      wv_d     = (wr_req & idle) | (wv_q & ~m_axil.wready);
      // response phase opens only once both AW and W have been accepted
      bready_d = bready_q ? ~m_axil.bvalid : (awv_q | wv_q) & ~awv_d & ~wv_d;
      arv_d    = (rd_req & idle) | (arv_q & ~m_axil.arready);
      rready_d = rready_q ? ~m_axil.rvalid : arv_q & m_axil.arready;
      addr_d   = start ? addr : addr_q;
      wdata_d  = start ? wdata : wdata_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         awv_q    <= 1'b0;
         wv_q     <= 1'b0;
         bready_q <= 1'b0;
         arv_q    <= 1'b0;
         rready_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         awv_q    <= awv_d;
         wv_q     <= wv_d;
         bready_q <= bready_d;
         arv_q    <= arv_d;
         rready_q <= rready_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end
   assign m_axil.awaddr  = addr_q;
   assign m_axil.awvalid = awv_q;
   assign m_axil.wdata   = wdata_q;
   assign m_axil.wstrb   = 4'hF;
   assign m_axil.wvalid  = wv_q;
   assign m_axil.bready  = bready_q;
   assign m_axil.araddr  = addr_q;
   assign m_axil.arvalid = arv_q;
   assign m_axil.rready  = rready_q;
   assign ack   = (bready_q & m_axil.bvalid) | (rready_q & m_axil.rvalid);
   assign resp  = bready_q ? m_axil.bresp : m_axil.rresp;
   assign rdata = m_axil.rdata;
endmodule

// File: rtl/dma_sg_launcher.sv
// dma_sg_launcher: programs AXI DMA SG channels, polls DMASR for IOC/error, clears IOC, reports done/error
module dma_sg_launcher
   import dma_regs_pkg::*;
#(
   parameter logic [31:0] MM2S_CURDESC  = 32'hA001_0000,
   parameter logic [31:0] MM2S_TAILDESC = 32'hA001_0200,
   parameter logic [31:0] S2MM_CURDESC  = 32'hA001_0100,
   parameter logic [31:0] S2MM_TAILDESC = 32'hA001_0300,
   parameter int          ADDR_W        = 10,
   parameter int unsigned POLL_TIMEOUT  = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_done,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [2:0]  err_code,
   output logic [31:0] last_status,
   dma_sg_launcher_if.master m_axil
);
   state_t state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [31:0] poll_q, poll_d, last_q, last_d, rom_d, req_data, rdata;
   logic [9:0]  rom_a;
   logic [ADDR_W-1:0] req_addr;
   logic [2:0]  code_q, code_d;
   logic cfg_q, busy_q, busy_d, error_q, error_d, rd_sel_q, rd_sel_d, clr_sel_q, clr_sel_d;
   logic ioc_s_q, ioc_s_d, ioc_m_q, ioc_m_d, ioc_s_new, ioc_m_new;
   logic launch, wr_req, rd_req, ack;
   logic [1:0] resp;
   // S2MM is armed before MM2S so the receive side is ready when data starts moving
   always_comb begin
      case (step_q)
         4'd0:    begin rom_a = S2MM_CURDESC_LSB;  rom_d = S2MM_CURDESC;   end
         4'd1:    begin rom_a = S2MM_CURDESC_MSB;  rom_d = 32'h0;          end
         4'd2:    begin rom_a = S2MM_DMACR;        rom_d = DMACR_RS_IOCEN; end
         4'd3:    begin rom_a = S2MM_TAILDESC_MSB; rom_d = 32'h0;          end
         4'd4:    begin rom_a = S2MM_TAILDESC_LSB; rom_d = S2MM_TAILDESC;  end
         4'd5:    begin rom_a = MM2S_CURDESC_LSB;  rom_d = MM2S_CURDESC;   end
         4'd6:    begin rom_a = MM2S_CURDESC_MSB;  rom_d = 32'h0;          end
         4'd7:    begin rom_a = MM2S_DMACR;        rom_d = DMACR_RS_IOCEN; end
         4'd8:    begin rom_a = MM2S_TAILDESC_MSB; rom_d = 32'h0;          end
         default: begin rom_a = MM2S_TAILDESC_LSB; rom_d = MM2S_TAILDESC;  end
      endcase
   end
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      poll_d    = poll_q;
      last_d    = last_q;
      code_d    = code_q;
      busy_d    = busy_q;
      error_d   = error_q;
      rd_sel_d  = rd_sel_q;
      clr_sel_d = clr_sel_q;
      ioc_s_d   = ioc_s_q;
      ioc_m_d   = ioc_m_q;
      wr_req    = 1'b0;
      rd_req    = 1'b0;
      launch    = cfg_done & ~cfg_q & ~busy_q;
      ioc_s_new = ioc_s_q | (~rd_sel_q & last_q[DMASR_IOC]);
      ioc_m_new = ioc_m_q | (rd_sel_q & last_q[DMASR_IOC]);
      case (state_q)
         S_IDLE: if (launch) begin
            state_d   = S_WR_REQ;
            step_d    = 4'd0;
            poll_d    = 32'd0;
            busy_d    = 1'b1;
            error_d   = 1'b0;
            code_d    = ERR_NONE;
            rd_sel_d  = 1'b0;
            clr_sel_d = 1'b0;
            ioc_s_d   = 1'b0;
            ioc_m_d   = 1'b0;
         end
         S_WR_REQ: begin
            wr_req  = 1'b1;
            state_d = S_WR_RESP;
         end
         S_WR_RESP: if (ack) begin
            state_d = resp != 2'b00 ? S_ERR : step_q == LAST_STEP ? S_RD_REQ : S_WR_REQ;
            code_d  = resp != 2'b00 ? ERR_BRESP : code_q;
            step_d  = resp == 2'b00 && step_q != LAST_STEP ? step_q + 4'd1 : step_q;
         end
         S_RD_REQ: begin
            rd_req  = 1'b1;
            state_d = S_RD_RESP;
         end
         S_RD_RESP: if (ack) begin
            last_d  = rdata;
            state_d = resp != 2'b00 ? S_ERR : S_EVAL;
            code_d  = resp != 2'b00 ? ERR_RRESP : code_q;
         end
         S_EVAL: begin
            ioc_s_d = ioc_s_new;
            ioc_m_d = ioc_m_new;
            if (|(last_q & DMASR_ERR)) begin
               state_d = S_ERR;
               code_d  = rd_sel_q ? ERR_MM2S : ERR_S2MM;
            end else if (ioc_s_new && ioc_m_new) begin
               state_d   = S_CLR_REQ;
               clr_sel_d = 1'b0;
            end else if (poll_q == 32'(POLL_TIMEOUT - 1)) begin
               state_d = S_ERR;
               code_d  = ERR_TIMEOUT;
            end else begin
               state_d  = S_RD_REQ;
               rd_sel_d = ~rd_sel_q;
               poll_d   = poll_q + 32'd1;
            end
         end
         S_CLR_REQ: begin
            wr_req  = 1'b1;
            state_d = S_CLR_RESP;
         end
         S_CLR_RESP: if (ack) begin
            state_d   = resp != 2'b00 ? S_ERR : clr_sel_q ? S_DONE : S_CLR_REQ;
            code_d    = resp != 2'b00 ? ERR_BRESP : code_q;
            clr_sel_d = 1'b1;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ERR: begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      req_addr = state_q == S_WR_REQ ? ADDR_W'(rom_a)
               : state_q == S_RD_REQ ? ADDR_W'(rd_sel_q ? MM2S_DMASR : S2MM_DMASR)
               : ADDR_W'(clr_sel_q ? MM2S_DMASR : S2MM_DMASR);
      req_data = state_q == S_WR_REQ ? rom_d : DMASR_IOC_W1C;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         step_q    <= 4'd0;
         poll_q    <= 32'd0;
         last_q    <= 32'd0;
         code_q    <= ERR_NONE;
         cfg_q     <= 1'b0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
         rd_sel_q  <= 1'b0;
         clr_sel_q <= 1'b0;
         ioc_s_q   <= 1'b0;
         ioc_m_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         poll_q    <= poll_d;
         last_q    <= last_d;
         code_q    <= code_d;
         cfg_q     <= cfg_done;
         busy_q    <= busy_d;
         error_q   <= error_d;
         rd_sel_q  <= rd_sel_d;
         clr_sel_q <= clr_sel_d;
         ioc_s_q   <= ioc_s_d;
         ioc_m_q   <= ioc_m_d;
      end
   end
   axil_single_master #(.ADDR_W(ADDR_W)) u_axil (
      .clk    (clk),
      .rst    (rst),
      .wr_req (wr_req),
      .rd_req (rd_req),
      .addr   (req_addr),
      .wdata  (req_data),
      .ack    (ack),
      .resp   (resp),
      .rdata  (rdata),
      .m_axil (m_axil)
   );
   assign busy        = busy_q;
   assign done        = state_q == S_DONE;
   assign error       = error_q;
   assign err_code    = code_q;
   assign last_status = last_q;
endmodule

// File: tb/tb_dma_sg_launcher.sv
// tb_dma_sg_launcher: directed tests against a negedge-driven AXI-Lite slave model
module tb_dma_sg_launcher;
   logic clk = 1'b0, rst = 1'b1, cfg_done = 1'b0;
   logic busy, done, error;
   logic [2:0] err_code;
   logic [31:0] last_status;
   int n_cmp = 0, n_bad = 0;
   int aw_n, w_n, b_n, ar_n, r_n, alone_n, strb_bad, w_dly, w_wait, bad_b, dc;
   bit r_hold, b_fire, r_fire;
   logic [31:0] sts_s2mm, sts_mm2s;
   logic [9:0]  aw_log [64];
   logic [31:0] w_log  [64];
   logic [9:0]  ar_log [64];
   logic [9:0]  exp_a [12] = '{10'h38, 10'h3C, 10'h30, 10'h44, 10'h40,
                               10'h08, 10'h0C, 10'h00, 10'h14, 10'h10, 10'h34, 10'h04};
   logic [31:0] exp_d [12] = '{32'hA0010100, 32'h0, 32'h00001001, 32'h0, 32'hA0010300,
                               32'hA0010000, 32'h0, 32'h00001001, 32'h0, 32'hA0010200,
                               32'h00001000, 32'h00001000};
   dma_sg_launcher_if #(.ADDR_W(10)) axil ();
   dma_sg_launcher #(.POLL_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .cfg_done(cfg_done), .busy(busy), .done(done), .error(error),
      .err_code(err_code), .last_status(last_status), .m_axil(axil)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic clr_logs();
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0; alone_n = 0; strb_bad = 0; w_wait = 0;
   endtask
   task automatic launch_and_wait(output int done_cnt);
      cfg_done = 1'b0;
      @(negedge clk);
      cfg_done = 1'b1;
      done_cnt = 0;
      @(negedge clk);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (!busy) break;
      end
      check("run_ends", 32'(busy), 0);
   endtask
   // slave: B/R are scheduled before AW/W/AR so a response never precedes its request
   initial begin
      {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid} = '0;
      axil.bresp = 2'b00; axil.rresp = 2'b00; axil.rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            {axil.awready, axil.wready, axil.bvalid, axil.arready, axil.rvalid} = '0;
            b_fire = 0; r_fire = 0;
         end else begin
            if (b_fire) begin axil.bvalid = 1'b0; b_fire = 0; end
            if (!axil.bvalid && b_n < ((aw_n < w_n) ? aw_n : w_n)) begin
               axil.bvalid = 1'b1;
               axil.bresp  = (b_n == bad_b) ? 2'b10 : 2'b00;
            end
            if (axil.bvalid && axil.bready) begin b_fire = 1; b_n++; end
            if (r_fire) begin axil.rvalid = 1'b0; r_fire = 0; end
            if (!axil.rvalid && !r_hold && r_n < ar_n) begin
               axil.rvalid = 1'b1;
               axil.rdata  = ar_log[r_n] == 10'h04 ? sts_mm2s : sts_s2mm;
            end
            if (axil.rvalid && axil.rready) begin r_fire = 1; r_n++; end
            axil.awready = axil.awvalid;
            if (axil.awready) begin aw_log[aw_n] = axil.awaddr; aw_n++; end
            if (axil.wvalid && w_wait >= w_dly) begin
               axil.wready = 1'b1;
               w_log[w_n] = axil.wdata;
               if (axil.wstrb != 4'hF) strb_bad++;
               w_n++; w_wait = 0; w_dly = 0;
            end else begin
               axil.wready = 1'b0;
               if (axil.wvalid) w_wait++;
            end
            if (!axil.awvalid && axil.wvalid) alone_n++;
            axil.arready = axil.arvalid;
            if (axil.arready) begin ar_log[ar_n] = axil.araddr; ar_n++; end
         end
      end
   end
   initial begin
      clr_logs();
      w_dly = 0; bad_b = -1; r_hold = 0; sts_s2mm = 32'h1002; sts_mm2s = 32'h1002;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_err_code", 32'(err_code), 0);
      check("rst_valids", 32'({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs", 32'({busy, done, error}), 0);
      check("idle_last", last_status, 0);
      // full successful run: ROM writes, two polls, two W1C clears
      launch_and_wait(dc);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("t1_awaddr%0d", i), 32'(aw_log[i]), 32'(exp_a[i]));
         check($sformatf("t1_wdata%0d", i), w_log[i], exp_d[i]);
      end
      check("t1_aw_n", aw_n, 12);
      check("t1_b_n", b_n, 12);
      check("t1_ar_n", ar_n, 2);
      check("t1_ar0", 32'(ar_log[0]), 32'h34);
      check("t1_ar1", 32'(ar_log[1]), 32'h04);
      check("t1_done_pulses", dc, 1);
      check("t1_error", 32'(error), 0);
      check("t1_last_status", last_status, 32'h1002);
      check("t1_wstrb", strb_bad, 0);
      repeat (10) @(negedge clk);
      check("held_no_relaunch", 32'(busy), 0);
      check("held_aw_n", aw_n, 12);
      // W accepted three cycles after AW on write 0
      clr_logs(); w_dly = 3;
      launch_and_wait(dc);
      check("t3_alone_cycles", alone_n, 3);
      check("t3_aw_n", aw_n, 12);
      check("t3_w_n", w_n, 12);
      check("t3_b_n", b_n, 12);
      check("t3_wdata0", w_log[0], 32'hA0010100);
      check("t3_done", dc, 1);
      // SLVERR on write step 4
      clr_logs(); bad_b = 4;
      launch_and_wait(dc);
      check("t4_error", 32'(error), 1);
      check("t4_code", 32'(err_code), 1);
      check("t4_aw_n", aw_n, 5);
      check("t4_done", dc, 0);
      repeat (5) @(negedge clk);
      check("t4_no_more_aw", aw_n, 5);
      bad_b = -1;
      // MM2S DMASR reports an internal error
      clr_logs(); sts_s2mm = 32'h0; sts_mm2s = 32'h10;
      launch_and_wait(dc);
      check("t4b_code", 32'(err_code), 3);
      check("t4b_error", 32'(error), 1);
      check("t4b_last", last_status, 32'h10);
      check("t4b_ar_n", ar_n, 2);
      check("t4b_aw_n", aw_n, 10);
      // IOC never seen: timeout after exactly POLL_TIMEOUT reads
      clr_logs(); sts_s2mm = 32'h2; sts_mm2s = 32'h2;
      launch_and_wait(dc);
      check("t5_ar_n", ar_n, 8);
      check("t5_code", 32'(err_code), 5);
      check("t5_ar6", 32'(ar_log[6]), 32'h34);
      check("t5_ar7", 32'(ar_log[7]), 32'h04);
      check("t5_last", last_status, 32'h2);
      // reset while a status read is waiting for its R beat
      clr_logs(); sts_s2mm = 32'h1002; sts_mm2s = 32'h1002; r_hold = 1;
      cfg_done = 1'b0;
      @(negedge clk);
      cfg_done = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (axil.rready) break;
      end
      check("t6_in_rd_resp", 32'(axil.rready), 1);
      rst = 1'b1; cfg_done = 1'b0;
      @(negedge clk);
      check("t6_rst_outs", 32'({busy, done, error}), 0);
      check("t6_rst_code", 32'(err_code), 0);
      check("t6_rst_last", last_status, 0);
      check("t6_rst_valids", 32'({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}), 0);
      rst = 1'b0; r_hold = 0;
      clr_logs();
      @(negedge clk);
      launch_and_wait(dc);
      check("t6_aw0", 32'(aw_log[0]), 32'h38);
      check("t6_aw_n", aw_n, 12);
      check("t6_done", dc, 1);
      check("t6_error", 32'(error), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
